// File: rtl/serial_add2_unit.sv
// Multi-cycle WIDTH-bit adder/subtractor that resolves one 2-bit ripple-carry slice per clock.
// Define SERIAL_ADD_OVF_EN to build the signed-overflow flag; otherwise overflow is tied to 0.

module rca2bit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] sum,
    output logic       cout
);
    logic c1;

    always_comb begin
        sum[0] = a[0] ^ b[0] ^ cin;
        c1     = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));
        sum[1] = a[1] ^ b[1] ^ c1;
        cout   = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
    end
endmodule

module serial_add2_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             cout,
    output logic             overflow
);
    localparam int SLICES = WIDTH / 2;
    localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              cout_q, cout_d;

    logic [CW:0]       bit_idx;
    logic [1:0]        slice_a;
    logic [1:0]        slice_b;
    logic [1:0]        slice_sum;
    logic              slice_cout;
    logic              last_slice;

    assign bit_idx    = {count_q, 1'b0};
    assign slice_a    = a_q[bit_idx +: 2];
    assign slice_b    = b_q[bit_idx +: 2];
    assign last_slice = (count_q == LAST);

    rca2bit u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
                    state_d = RUN;
                    a_d     = data_operandA;
                    b_d     = data_operandB ^ {WIDTH{ctrl_sub}};
                    carry_d = ctrl_sub;
                    count_d = '0;
                end
            end
            RUN: begin
                result_d[bit_idx +: 2] = slice_sum;
                carry_d                = slice_cout;
                if (last_slice) begin
                    state_d = DONE;
                    cout_d  = slice_cout;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign data_result = result_q;
    assign cout        = cout_q;

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q, ovf_d;
    logic carry_into_msb;

    // The carry into the MSB is the slice's internal carry, recovered as a ^ b ^ sum at bit 1.
    assign carry_into_msb = slice_a[1] ^ slice_b[1] ^ slice_sum[1];

    always_comb begin
        ovf_d = ovf_q;
        if (state_q == RUN && last_slice) begin
            ovf_d = carry_into_msb ^ slice_cout;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add2_unit.sv
// Self-checking bench for serial_add2_unit (WIDTH=32): a scoreboard queue of expected results,
// filled when an operation is accepted and drained when the unit presents out_valid.

module tb_serial_add2_unit;

    localparam int WIDTH   = 32;
    localparam int LATENCY = WIDTH / 2;

    logic             clock;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_result;
    logic             cout;
    logic             overflow;

    typedef struct {
        logic [WIDTH-1:0] result;
        logic             carry;
        logic             ovf;
    } exp_t;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    serial_add2_unit #(.WIDTH(WIDTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .ctrl_sub      (ctrl_sub),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .data_result   (data_result),
        .cout          (cout),
        .overflow      (overflow)
    );

    // Free-running 100 MHz clock
    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports any mismatch
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Reference model: 33-bit add of A and (optionally inverted) B with carry-in
    function automatic exp_t refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        exp_t             e;
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   full;
        bb       = s ? ~b : b;
        full     = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, s};
        e.result = full[WIDTH-1:0];
        e.carry  = full[WIDTH];
`ifdef SERIAL_ADD_OVF_EN
        e.ovf    = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
`else
        e.ovf    = 1'b0;
`endif
        return e;
    endfunction

    // Present one operation from IDLE, push its expectation, and return just after the accept edge
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        checkOutput("pre_accept_in_ready", 32'(in_ready), 32'd1);
        sb.push_back(refModel(a, b, s));
        data_operandA = a;
        data_operandB = b;
        ctrl_sub      = s;
        in_valid      = 1'b1;
        @(posedge clock);
        #1;
        in_valid      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        ctrl_sub      = 1'($urandom_range(0, 1));
    endtask

    // Wait (bounded) for out_valid, check latency and the popped expectation, optionally stall
    // the consumer, pulse in_valid mid-RUN, or offer a new op in the handshake cycle.
    task automatic awaitResult(input string tag, input int hold, input bit pulse_run, input bit poke_ack);
        int   edges;
        exp_t e;
        edges = 0;
        while (!out_valid && edges < 4 * LATENCY) begin
            @(posedge clock);
            #1;
            edges++;
            if (pulse_run) begin
                if (!out_valid) checkOutput({tag, "_run_in_ready"}, 32'(in_ready), 32'd0);
                if (edges == 3) begin
                    data_operandA = 32'hDEAD_BEEF;
                    data_operandB = 32'h0BAD_F00D;
                    ctrl_sub      = 1'b0;
                    in_valid      = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        checkOutput({tag, "_latency"}, 32'(edges), 32'(LATENCY));
        if (sb.size() == 0) begin
            checkOutput({tag, "_scoreboard_empty"}, 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        if (!out_valid) begin
            checkOutput({tag, "_out_valid_timeout"}, 32'(out_valid), 32'd1);
            return;
        end
        for (int i = 0; i <= hold; i++) begin
            checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, "_result"}, data_result, e.result);
            checkOutput({tag, "_cout"}, 32'(cout), 32'(e.carry));
            checkOutput({tag, "_overflow"}, 32'(overflow), 32'(e.ovf));
            if (i > 0) checkOutput({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            if (i < hold) begin
                @(posedge clock);
                #1;
            end
        end
        out_ready = 1'b1;
        if (poke_ack) begin
            data_operandA = 32'h1111_1111;
            data_operandB = 32'h2222_2222;
            in_valid      = 1'b1;
        end
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput({tag, "_ack_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_ack_in_ready"}, 32'(in_ready), 32'd1);
        checkOutput({tag, "_after_ack_result"}, data_result, e.result);
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rs;
        bit               extra;

        vectors       = 0;
        miscompares   = 0;
        clock         = 1'b0;
        reset         = 1'b0;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        ctrl_sub      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;

        // Reset values while reset is held low
        #12;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_result", data_result, 32'd0);
        checkOutput("rst_cout", 32'(cout), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Directed arithmetic cases
        applyStimulus(32'h0000_0001, 32'h0000_0001, 1'b0);
        awaitResult("t1_add", 0, 1'b0, 1'b0);
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        awaitResult("t2_carry", 0, 1'b0, 1'b0);
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        awaitResult("t3_ovf", 0, 1'b0, 1'b0);
        applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b1);
        awaitResult("t4_sub", 0, 1'b0, 1'b0);

        // Stall in DONE, ignored mid-RUN pulse, new op offered in the handshake cycle
        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0);
        awaitResult("t5_stall", 5, 1'b1, 1'b1);
        extra = 1'b0;
        for (int i = 0; i < LATENCY + 4; i++) begin
            if (out_valid || !in_ready) extra = 1'b1;
            @(posedge clock);
            #1;
        end
        checkOutput("t5_no_second_result", 32'(extra), 32'd0);

        // Asynchronous reset in the middle of RUN
        applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0);
        repeat (8) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t6_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t6_rst_result", data_result, 32'd0);
        checkOutput("t6_rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("t6_rst_cout", 32'(cout), 32'd0);
        void'(sb.pop_back());
        #4;
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("t6_post_rst_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(32'h0000_0003, 32'h0000_0004, 1'b0);
        awaitResult("t6_after", 0, 1'b0, 1'b0);

        // Random operations with random consumer stalls
        for (int n = 0; n < 10; n++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            applyStimulus(ra, rb, rs);
            awaitResult("rand", $urandom_range(0, 3), 1'b0, 1'b0);
        end

        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
